// File: rtl/dsp_loop_ctrl_if.sv
// Loop controller bus: Decode/Branch requests and PC in, Fetch jump port out.
//   master : Decode/Branch/Fetch side (drives pc, loop and branch requests)
//   slave  : dsp_loop_ctrl (drives jump_flag/jump_addr back to Fetch)
interface dsp_loop_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] pc;
  logic              loop_start;
  logic [ADDR_W-1:0] loop_end_addr;
  logic [CNT_W-1:0]  loop_count;
  logic              loop_break;
  logic              branch_req;
  logic [ADDR_W-1:0] branch_addr;
  logic              jump_flag;
  logic [ADDR_W-1:0] jump_addr;

  modport master (
    output pc, loop_start, loop_end_addr, loop_count, loop_break,
           branch_req, branch_addr,
    input  jump_flag, jump_addr
  );

  modport slave (
    input  pc, loop_start, loop_end_addr, loop_count, loop_break,
           branch_req, branch_addr,
    output jump_flag, jump_addr
  );
endinterface

// File: rtl/dsp_loop_ctrl.sv
// Zero-overhead hardware loop controller. Holds a stack of nested loop
// contexts {start, end, count}, compares the top context's end address with
// the fetch PC and drives Fetch's jump port (shared with ordinary branches).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : dsp_loop_ctrl_if.slave (pc, loop/branch requests in; jump out)
//   depth    : number of active loop contexts
//   err      : sticky overflow/underflow/illegal-push flag
module dsp_loop_ctrl #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  dsp_loop_ctrl_if.slave             bus,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       err
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] start_q [DEPTH];
  logic [ADDR_W-1:0] end_q   [DEPTH];
  logic [CNT_W-1:0]  cnt_q   [DEPTH];
  logic [DW-1:0]     depth_q;
  logic              err_q;

  logic [DW-1:0]     depth_m1;
  logic [IW-1:0]     top_idx;
  logic [ADDR_W-1:0] top_start;
  logic [ADDR_W-1:0] top_end;
  logic [CNT_W-1:0]  top_cnt;
  logic [ADDR_W-1:0] pc_inc;
  logic              has_ctx;
  logic              end_hit;
  logic              cnt_gt1;
  logic              zero_cnt;
  logic              iter_end;
  logic              dec;
  logic              do_pop;
  logic              underflow;
  logic              push_req;
  logic              push_bad;
  logic              do_push;
  logic [DW-1:0]     base;
  logic [IW-1:0]     push_idx;

  assign depth_m1 = depth_q - DW'(1);
  assign top_idx  = depth_m1[IW-1:0];
  assign pc_inc   = bus.pc + ADDR_W'(1);
  assign has_ctx  = (depth_q != '0);

  // Top-of-stack read mux; loop compare keeps the index in range for any DEPTH.
  always_comb begin
    top_start = '0;
    top_end   = '0;
    top_cnt   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (IW'(i) == top_idx) begin
        top_start = start_q[i];
        top_end   = end_q[i];
        top_cnt   = cnt_q[i];
      end
    end
  end

  assign end_hit  = has_ctx && (bus.pc == top_end);
  assign cnt_gt1  = (top_cnt > CNT_W'(1));
  assign zero_cnt = bus.loop_start && (bus.loop_count == '0);

  always_comb begin
    bus.jump_flag = 1'b0;
    bus.jump_addr = '0;
    if (bus.branch_req) begin
      bus.jump_flag = 1'b1;
      bus.jump_addr = bus.branch_addr;
    end else if (zero_cnt) begin
      bus.jump_flag = 1'b1;
      bus.jump_addr = bus.loop_end_addr + ADDR_W'(1);
    end else if (end_hit && cnt_gt1) begin
      bus.jump_flag = 1'b1;
      bus.jump_addr = top_start;
    end
  end

  // Final-iteration pop and loop_break merge into a single pop.
  assign iter_end  = end_hit && !bus.branch_req;
  assign dec       = iter_end && cnt_gt1;
  assign do_pop    = has_ctx && ((iter_end && !cnt_gt1) || bus.loop_break);
  assign underflow = bus.loop_break && !has_ctx;

  assign push_req = bus.loop_start && (bus.loop_count != '0) && !bus.branch_req;
  assign push_bad = (depth_q == DW'(DEPTH)) || end_hit ||
                    (has_ctx && (bus.loop_end_addr == top_end)) ||
                    (bus.loop_end_addr < pc_inc);
  assign do_push  = push_req && !push_bad;

  // A push lands on top of whatever survives this cycle's pop.
  assign base     = do_pop ? depth_m1 : depth_q;
  assign push_idx = base[IW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        start_q[i] <= '0;
        end_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (dec && (IW'(i) == top_idx)) begin
          cnt_q[i] <= top_cnt - CNT_W'(1);
        end
        if (do_push && (IW'(i) == push_idx)) begin
          start_q[i] <= pc_inc;
          end_q[i]   <= bus.loop_end_addr;
          cnt_q[i]   <= bus.loop_count;
        end
      end
      depth_q <= do_push ? base + DW'(1) : base;
      err_q   <= err_q | underflow | (push_req && push_bad);
    end
  end

  assign depth = depth_q;
  assign err   = err_q;
endmodule

// File: tb/tb_dsp_loop_ctrl.sv
module tb_dsp_loop_ctrl;
  localparam int DEPTH = 4;

  typedef struct {
    logic [15:0] s;
    logic [15:0] e;
    logic [15:0] c;
  } ctx_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] depth;
  logic       err;

  dsp_loop_ctrl_if #(.ADDR_W(16), .CNT_W(16)) bus ();

  dsp_loop_ctrl #(.ADDR_W(16), .CNT_W(16), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .depth (depth),
    .err   (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int checks   = 0;
  int failures = 0;

  // reference model state
  ctx_t stk[$];
  logic m_err;

  // driven input values
  logic [15:0] d_pc, d_le, d_lc, d_ba;
  logic        d_ls, d_brk, d_br;

  // observations for directed checks
  logic        obs_jf;
  logic [15:0] obs_ja;
  int          jumps, peak, visits;

  int prog_end [int];
  int prog_cnt [int];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_jump(output logic f, output logic [15:0] a);
    f = 1'b0;
    a = '0;
    if (d_br) begin
      f = 1'b1; a = d_ba;
    end else if (d_ls && d_lc == 0) begin
      f = 1'b1; a = d_le + 16'd1;
    end else if (stk.size() > 0 && d_pc == stk[$].e && stk[$].c > 1) begin
      f = 1'b1; a = stk[$].s;
    end
  endfunction

  function automatic void model_clock();
    int n = stk.size();
    bit hit = (n > 0) && (d_pc == stk[n-1].e);
    bit popped = 0;
    logic [15:0] top_e = (n > 0) ? stk[n-1].e : 16'd0;
    logic [15:0] nxt = d_pc + 16'd1;
    if (hit && !d_br) begin
      if (stk[n-1].c > 1) stk[n-1].c = stk[n-1].c - 16'd1;
      else popped = 1;
    end
    if (d_brk) begin
      if (n == 0) m_err = 1'b1;
      else popped = 1;
    end
    if (popped) void'(stk.pop_back());
    if (d_ls && d_lc != 0 && !d_br) begin
      if (n == DEPTH || hit || (n > 0 && d_le == top_e) || d_le < nxt) m_err = 1'b1;
      else stk.push_back('{nxt, d_le, d_lc});
    end
  endfunction

  task automatic drive();
    bus.pc            = d_pc;
    bus.loop_start    = d_ls;
    bus.loop_end_addr = d_le;
    bus.loop_count    = d_lc;
    bus.loop_break    = d_brk;
    bus.branch_req    = d_br;
    bus.branch_addr   = d_ba;
  endtask

  // One cycle: drive at negedge, check jump outputs, clock, check state.
  task automatic step(input logic [15:0] p, input logic ls, input logic [15:0] le,
                      input logic [15:0] lc, input logic brk, input logic br,
                      input logic [15:0] ba, output logic ef, output logic [15:0] ea);
    d_pc = p; d_ls = ls; d_le = le; d_lc = lc; d_brk = brk; d_br = br; d_ba = ba;
    drive();
    #1;
    model_jump(ef, ea);
    obs_jf = bus.jump_flag;
    obs_ja = bus.jump_addr;
    chk("jump_flag", {31'd0, obs_jf}, {31'd0, ef});
    chk("jump_addr", {16'd0, obs_ja}, {16'd0, ea});
    if (obs_jf) jumps++;
    @(posedge clk);
    model_clock();
    #1;
    chk("depth", {29'd0, depth}, stk.size());
    chk("err", {31'd0, err}, {31'd0, m_err});
    if (int'(depth) > peak) peak = int'(depth);
    @(negedge clk);
  endtask

  task automatic do_reset();
    d_pc = '0; d_ls = 0; d_le = '0; d_lc = '0; d_brk = 0; d_br = 0; d_ba = '0;
    drive();
    rst = 1'b1;
    stk.delete();
    m_err = 1'b0;
    #1;
    chk("rst_depth", {29'd0, depth}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_jump", {31'd0, bus.jump_flag}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs the loaded program from pc0, following the model's jumps.
  task automatic run_prog(input logic [15:0] pc0, input logic [15:0] stop_pc,
                          input logic [15:0] watch_pc, input int budget);
    logic [15:0] p;
    logic ef;
    logic [15:0] ea;
    int k;
    p = pc0; k = 0; jumps = 0; peak = 0; visits = 0;
    while (p != stop_pc && k < budget) begin
      if (p == watch_pc) visits++;
      if (prog_cnt.exists(int'(p)))
        step(p, 1, 16'(prog_end[int'(p)]), 16'(prog_cnt[int'(p)]), 0, 0, 0, ef, ea);
      else
        step(p, 0, 0, 0, 0, 0, 0, ef, ea);
      p = ef ? ea : p + 16'd1;
      k++;
    end
    chk("prog_reached_stop", {16'd0, p}, {16'd0, stop_pc});
  endtask

  initial begin
    logic ef;
    logic [15:0] ea;
    logic [15:0] p;
    m_err = 1'b0;
    @(negedge clk);
    do_reset();

    // single loop: pc=10, end=13, count=3
    prog_end.delete(); prog_cnt.delete();
    prog_end[10] = 13; prog_cnt[10] = 3;
    run_prog(16'd10, 16'd14, 16'd11, 50);
    chk("single_jumps", jumps, 32'd2);
    chk("single_body_passes", visits, 32'd3);
    chk("single_peak", peak, 32'd1);
    chk("single_end_depth", {29'd0, depth}, 32'd0);

    // zero count: skipped entirely in the same cycle
    step(16'd20, 1, 16'd25, 16'd0, 0, 0, 0, ef, ea);
    chk("zero_flag", {31'd0, obs_jf}, 32'd1);
    chk("zero_addr", {16'd0, obs_ja}, 32'd26);
    chk("zero_depth", {29'd0, depth}, 32'd0);

    // nesting: outer pc=0 end=9 cnt=2, inner pc=2 end=5 cnt=3
    prog_end.delete(); prog_cnt.delete();
    prog_end[0] = 9; prog_cnt[0] = 2;
    prog_end[2] = 5; prog_cnt[2] = 3;
    run_prog(16'd0, 16'd10, 16'd3, 200);
    chk("nest_inner_passes", visits, 32'd6);
    chk("nest_jumps", jumps, 32'd5);
    chk("nest_peak", peak, 32'd2);
    chk("nest_end_depth", {29'd0, depth}, 32'd0);

    // branch priority over loop-back, no decrement, then loop_break
    do_reset();
    step(16'd30, 1, 16'd33, 16'd2, 0, 0, 0, ef, ea);
    step(16'd31, 0, 0, 0, 0, 0, 0, ef, ea);
    step(16'd32, 0, 0, 0, 0, 0, 0, ef, ea);
    step(16'd33, 0, 0, 0, 0, 1, 16'd40, ef, ea);
    chk("prio_addr", {16'd0, obs_ja}, 32'd40);
    step(16'd33, 0, 0, 0, 0, 0, 0, ef, ea);
    chk("prio_cnt_kept_flag", {31'd0, obs_jf}, 32'd1);
    chk("prio_cnt_kept_addr", {16'd0, obs_ja}, 32'd31);
    step(16'd40, 0, 0, 0, 1, 0, 0, ef, ea);
    chk("break_depth", {29'd0, depth}, 32'd0);
    chk("break_err", {31'd0, err}, 32'd0);

    // overflow: DEPTH+1 nested pushes
    do_reset();
    for (int i = 0; i <= DEPTH; i++)
      step(16'(i), 1, 16'(100 - i), 16'd2, 0, 0, 0, ef, ea);
    chk("ovf_depth", {29'd0, depth}, DEPTH);
    chk("ovf_err", {31'd0, err}, 32'd1);

    // underflow
    do_reset();
    step(16'd0, 0, 0, 0, 1, 0, 0, ef, ea);
    chk("udf_err", {31'd0, err}, 32'd1);
    chk("udf_depth", {29'd0, depth}, 32'd0);

    // illegal pushes: shared end, backward body, LOOP at enclosing end
    do_reset();
    step(16'd10, 1, 16'd20, 16'd2, 0, 0, 0, ef, ea);
    step(16'd11, 1, 16'd20, 16'd2, 0, 0, 0, ef, ea);
    chk("shared_end_err", {31'd0, err}, 32'd1);
    do_reset();
    step(16'd10, 1, 16'd5, 16'd2, 0, 0, 0, ef, ea);
    chk("backward_err", {31'd0, err}, 32'd1);
    do_reset();
    step(16'd10, 1, 16'd15, 16'd2, 0, 0, 0, ef, ea);
    step(16'd15, 1, 16'd18, 16'd2, 0, 0, 0, ef, ea);
    chk("push_at_end_err", {31'd0, err}, 32'd1);
    chk("push_at_end_depth", {29'd0, depth}, 32'd1);

    // async reset mid-loop at depth 2
    do_reset();
    step(16'd50, 1, 16'd60, 16'd5, 0, 0, 0, ef, ea);
    step(16'd51, 1, 16'd55, 16'd3, 0, 0, 0, ef, ea);
    chk("pre_rst_depth", {29'd0, depth}, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_depth", {29'd0, depth}, 32'd0);
    chk("async_rst_err", {31'd0, err}, 32'd0);
    stk.delete();
    m_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(16'd55, 0, 0, 0, 0, 0, 0, ef, ea);
    chk("post_rst_nojump", {31'd0, obs_jf}, 32'd0);
    step(16'd60, 0, 0, 0, 0, 0, 0, ef, ea);

    // randomized traffic against the reference model
    for (int it = 0; it < 400; it++) begin
      if (it % 50 == 0) do_reset();
      if (stk.size() > 0 && $urandom_range(0, 1) == 1) p = stk[$].e;
      else p = 16'($urandom_range(0, 31));
      step(p,
           ($urandom_range(0, 3) == 0),
           p + 16'($urandom_range(0, 8)),
           16'($urandom_range(0, 3)),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 9) == 0),
           16'($urandom),
           ef, ea);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
